lfsr_sequence_controller: RTL



---
 rtl/lfsr_sequence_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_sequence_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lfsr_sequence_controller
// Summary  : Command sequencer for lfsr_fibonacci: program length/taps, reload
//            the seed, then step N times, free-run, or measure the period.
//            Optional macro KWR_LFSR_CTRL_TIMEOUT_EN: MEASURE ends with
//            TIMEOUT when the step counter reaches its maximum.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_sequence_controller #(
  parameter int               CNT_W = 16,
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [2:0]       i_cmd_length,
  input  logic             i_cmd_n_taps,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic             i_abort,
  output logic [2:0]       o_lfsr_length,
  output logic             o_lfsr_n_taps,
  output logic             o_lfsr_load,
  output logic             o_lfsr_step,
  input  logic [WIDTH-1:0] i_lfsr_value,
  input  logic             i_lfsr_valid,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [1:0]       o_res_status,
  output logic [CNT_W-1:0] o_res_count,
  output logic             o_busy
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_CONFIG  = 3'd1;
  localparam logic [2:0] c_CHECK   = 3'd2;
  localparam logic [2:0] c_RUN     = 3'd3;
  localparam logic [2:0] c_MEASURE = 3'd4;
  localparam logic [2:0] c_FREE    = 3'd5;
  localparam logic [2:0] c_DONE    = 3'd6;

  localparam logic [1:0] c_OP_RUN     = 2'b00;
  localparam logic [1:0] c_OP_MEASURE = 2'b01;
  localparam logic [1:0] c_OP_FREE    = 2'b10;

  localparam logic [1:0] c_ST_OK      = 2'b00;
  localparam logic [1:0] c_ST_INVALID = 2'b01;
  localparam logic [1:0] c_ST_ABORTED = 2'b10;
`ifdef KWR_LFSR_CTRL_TIMEOUT_EN
  localparam logic [1:0] c_ST_TIMEOUT = 2'b11;
`endif

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [1:0]       r_cmd_op;
  logic [2:0]       r_cmd_length;
  logic             r_cmd_n_taps;
  logic [CNT_W-1:0] r_cmd_count;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_lfsr_length;
  logic             r_lfsr_n_taps;
  logic [1:0]       r_res_status;
  logic [CNT_W-1:0] r_res_count;

  logic [2:0]       w_next_state;
  logic             w_accept;
  logic             w_step;
  logic             w_cnt_inc;
  logic             w_finish;
  logic [1:0]       w_fin_status;
  logic [CNT_W-1:0] w_fin_count;

  assign w_accept = i_cmd_valid && (r_state == c_IDLE);

  always_comb begin
    w_next_state = r_state;
    w_step       = 1'b0;
    w_cnt_inc    = 1'b0;
    w_finish     = 1'b0;
    w_fin_status = c_ST_OK;
    w_fin_count  = r_count;
    case (r_state)
      c_IDLE: begin
        if (w_accept) w_next_state = c_CONFIG;
      end
      c_CONFIG: begin
        w_next_state = c_CHECK;
      end
      c_CHECK: begin
        w_fin_count = '0;
        if (i_abort) begin
          w_finish     = 1'b1;
          w_fin_status = c_ST_ABORTED;
        end else if (!i_lfsr_valid) begin
          w_finish     = 1'b1;
          w_fin_status = c_ST_INVALID;
        end else begin
          case (r_cmd_op)
            c_OP_RUN:     w_next_state = c_RUN;
            c_OP_MEASURE: w_next_state = c_MEASURE;
            c_OP_FREE:    w_next_state = c_FREE;
            default: begin
              w_finish     = 1'b1;
              w_fin_status = c_ST_INVALID;
            end
          endcase
        end
      end
      c_RUN: begin
        if (i_abort) begin
          w_finish     = 1'b1;
          w_fin_status = c_ST_ABORTED;
        end else if (r_count == r_cmd_count) begin
          w_finish = 1'b1;
        end else begin
          w_step    = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end
      c_MEASURE: begin
        // The seed is present on entry with zero steps; only a revisit ends the measurement.
        if (i_abort) begin
          w_finish     = 1'b1;
          w_fin_status = c_ST_ABORTED;
        end else if ((i_lfsr_value == SEED) && (r_count != '0)) begin
          w_finish = 1'b1;
`ifdef KWR_LFSR_CTRL_TIMEOUT_EN
        end else if (r_count == c_CNT_MAX) begin
          w_finish     = 1'b1;
          w_fin_status = c_ST_TIMEOUT;
`endif
        end else begin
          w_step    = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end
      c_FREE: begin
        if (i_abort) begin
          w_finish     = 1'b1;
          w_fin_status = c_ST_ABORTED;
        end else begin
          w_step    = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end
      c_DONE: begin
        if (i_res_ready) w_next_state = c_IDLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
    if (w_finish) w_next_state = c_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_cmd_op      <= 2'b00;
      r_cmd_length  <= 3'd0;
      r_cmd_n_taps  <= 1'b0;
      r_cmd_count   <= '0;
      r_count       <= '0;
      r_lfsr_length <= 3'd0;
      r_lfsr_n_taps <= 1'b0;
      r_res_status  <= c_ST_OK;
      r_res_count   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cmd_op     <= i_cmd_op;
        r_cmd_length <= i_cmd_length;
        r_cmd_n_taps <= i_cmd_n_taps;
        r_cmd_count  <= i_cmd_count;
        r_count      <= '0;
      end else if (w_cnt_inc && (r_count != c_CNT_MAX)) begin
        r_count <= r_count + c_CNT_ONE;
      end
      if (r_state == c_CONFIG) begin
        r_lfsr_length <= r_cmd_length;
        r_lfsr_n_taps <= r_cmd_n_taps;
      end
      if (w_finish) begin
        r_res_status <= w_fin_status;
        r_res_count  <= w_fin_count;
      end
    end
  end

  assign o_cmd_ready   = (r_state == c_IDLE);
  assign o_busy        = (r_state != c_IDLE);
  assign o_lfsr_load   = (r_state == c_CONFIG);
  assign o_lfsr_step   = w_step;
  assign o_lfsr_length = r_lfsr_length;
  assign o_lfsr_n_taps = r_lfsr_n_taps;
  assign o_res_valid   = (r_state == c_DONE);
  assign o_res_status  = r_res_status;
  assign o_res_count   = r_res_count;

endmodule
`default_nettype wire
